// File: rtl/regfile_ctx_engine.sv
// Context save/restore sequencer: moves every architectural register between
// the register file and a single-outstanding-request memory port.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  S_IDLE     | waiting for start; mode/base_addr latched on start
//  S_SAVE_RD  | present idx to RF read port, capture data and address
//  S_SAVE_REQ | write request to memory, held until mem_ready
//  S_RST_REQ  | read request to memory, held until mem_ready
//  S_RST_WAIT | waiting for mem_rvalid, capture read data
//  S_RST_WR   | one-cycle RF write of the captured data at idx
//  S_DONE     | one-cycle done pulse, busy low
module regfile_ctx_engine #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [3:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_RD,
        S_SAVE_REQ,
        S_RST_REQ,
        S_RST_WAIT,
        S_RST_WR,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic       last_idx;
    logic [3:0] idx_inc;

    assign last_idx = (idx_q == LAST_IDX);
    assign idx_inc  = idx_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wrdata_q <= wrdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wrdata_d = wrdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    idx_d   = '0;
                    // restore issues its request in the very next cycle, so
                    // the first address is loaded here
                    addr_d  = base_addr;
                    state_d = mode ? S_RST_REQ : S_SAVE_RD;
                end
            end
            S_SAVE_RD: begin
                wdata_d = rf_read_data;
                addr_d  = base_q + ADDR_W'(idx_q);
                state_d = S_SAVE_REQ;
            end
            S_SAVE_REQ: begin
                if (mem_ready) begin
                    if (last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_SAVE_RD;
                    end
                end
            end
            S_RST_REQ: begin
                if (mem_ready) begin
                    state_d = S_RST_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (mem_rvalid) begin
                    wrdata_d = mem_rdata;
                    state_d  = S_RST_WR;
                end
            end
            S_RST_WR: begin
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_inc;
                    addr_d  = base_q + ADDR_W'(idx_inc);
                    state_d = S_RST_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    assign mem_valid       = (state_q == S_SAVE_REQ) || (state_q == S_RST_REQ);
    assign mem_we          = (state_q == S_SAVE_REQ);
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign rf_read_reg     = idx_q;
    assign rf_write_reg    = idx_q;
    assign rf_write_data   = wrdata_q;
    assign rf_write_enable = (state_q == S_RST_WR);

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine: register file and memory models
// driven on the falling edge, per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_regfile_ctx_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        busy, done;
    logic [3:0]  rf_read_reg, rf_write_reg;
    logic [15:0] rf_read_data, rf_write_data;
    logic        rf_write_enable;
    logic        mem_valid, mem_we;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;

    regfile_ctx_engine #(.NUM_REGS(16), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .busy(busy), .done(done),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] rf  [0:15];
    logic [15:0] mem [0:65535];
    assign rf_read_data = rf[rf_read_reg];

    int vectors = 0;
    int miscompares = 0;

    // model controls and observations
    int          stall_n = 0, stall_cnt = 0, lat_mode = 0;
    bit          spur_en = 0, pending = 0, cur_mode = 0;
    int          rd_cnt = 0, lat_sum = 0;
    logic [15:0] rd_addr;
    bit          prev_stall = 0, prev_we = 0, prev_wen = 0;
    logic [15:0] prev_addr, prev_wdata;
    int          hs_n = 0, wr_n = 0, busy_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int          stab_err = 0, we_save_err = 0, valid_idle_err = 0, we_len_err = 0;
    logic [15:0] hs_addr [0:63];
    logic [15:0] hs_data [0:63];
    logic        hs_we   [0:63];

    always @(negedge clk) begin
        int lat;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        if (pending) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[rd_addr];
                pending    = 0;
            end
        end else if (spur_en && mem_valid && !mem_we) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
        end
        if (prev_stall) begin
            if (mem_valid !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we ||
                (mem_we && mem_wdata !== prev_wdata))
                stab_err++;
        end
        if (mem_valid) begin
            if (stall_cnt < stall_n) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            mem_ready = (stall_n == 0);
        end
        prev_stall = mem_valid && !mem_ready;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_we    = mem_we;
        if (mem_valid && mem_ready) begin
            if (hs_n < 64) begin
                hs_addr[hs_n] = mem_addr;
                hs_data[hs_n] = mem_wdata;
                hs_we[hs_n]   = mem_we;
            end
            hs_n++;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
            end else begin
                lat = (lat_mode == 0) ? 1 : (lat_mode == 2) ? 4 : int'($urandom_range(4, 1));
                pending = 1;
                rd_cnt  = lat;
                rd_addr = mem_addr;
                lat_sum += lat;
            end
        end
        busy_cnt  += int'(busy);
        done_cnt  += int'(done);
        valid_cnt += int'(mem_valid);
        if (mem_valid && !busy) valid_idle_err++;
        if (rf_write_enable) begin
            if (!cur_mode) we_save_err++;
            if (prev_wen) we_len_err++;
            rf[rf_write_reg] = rf_write_data;
            wr_n++;
        end
        prev_wen = rf_write_enable;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_op(input logic m, input logic [15:0] b);
        @(negedge clk);
        #1;
        busy_cnt = 0; done_cnt = 0; hs_n = 0; wr_n = 0; lat_sum = 0; valid_cnt = 0;
        stab_err = 0; we_save_err = 0; valid_idle_err = 0; we_len_err = 0;
        cur_mode = m; start = 1'b1; mode = m; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, mem_valid, mem_we, rf_write_enable} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, mem_valid, mem_we, rf_write_enable});
        end
        vectors++;
        if ({mem_addr, mem_wdata, rf_write_data} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rf_write_data});
        end
        vectors++;
        if ({rf_read_reg, rf_write_reg} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_idx: got %h expected 00", {rf_read_reg, rf_write_reg});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_save();
        bit ok;
        for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
        stall_n = 0;
        start_op(1'b0, 16'h0100);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL save_done_timeout: got no done expected done"); end
        vectors++;
        if (hs_n != 16) begin miscompares++; $display("FAIL save_hs_count: got %0d expected 16", hs_n); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (hs_addr[i] !== 16'h0100 + 16'(i) || hs_data[i] !== 16'hA000 + 16'(i) || hs_we[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL save_req[%0d]: got addr %h data %h we %b expected %h %h 1",
                         i, hs_addr[i], hs_data[i], hs_we[i], 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            end
        end
        vectors++;
        if (busy_cnt != 32) begin miscompares++; $display("FAIL save_busy_cycles: got %0d expected 32", busy_cnt); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL save_done_pulses: got %0d expected 1", done_cnt); end
        vectors++;
        if (we_save_err != 0 || valid_idle_err != 0) begin
            miscompares++;
            $display("FAIL save_illegal_strobes: got we=%0d valid_idle=%0d expected 0 0", we_save_err, valid_idle_err);
        end
    endtask

    task automatic test_save_stall();
        bit ok;
        for (int i = 0; i < 16; i++) rf[i] = 16'h3C00 + 16'(i);
        stall_n = 3;
        start_op(1'b0, 16'h0180);
        wait_done(400, ok);
        stall_n = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stall_done_timeout: got no done expected done"); end
        vectors++;
        if (hs_n != 16) begin miscompares++; $display("FAIL stall_hs_count: got %0d expected 16", hs_n); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (hs_addr[i] !== 16'h0180 + 16'(i) || hs_data[i] !== 16'h3C00 + 16'(i)) begin
                miscompares++;
                $display("FAIL stall_req[%0d]: got addr %h data %h expected %h %h",
                         i, hs_addr[i], hs_data[i], 16'h0180 + 16'(i), 16'h3C00 + 16'(i));
            end
        end
        vectors++;
        if (stab_err != 0) begin miscompares++; $display("FAIL stall_stability: got %0d changes expected 0", stab_err); end
        vectors++;
        if (busy_cnt != 80) begin miscompares++; $display("FAIL stall_busy_cycles: got %0d expected 80", busy_cnt); end
    endtask

    task automatic test_restore();
        bit ok;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0200 + 16'(i)] = 16'h5A00 + 16'(i);
            rf[i] = 16'h0000;
        end
        lat_mode = 1;
        spur_en  = 1;
        start_op(1'b1, 16'h0200);
        wait_done(400, ok);
        lat_mode = 0;
        spur_en  = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL restore_done_timeout: got no done expected done"); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (rf[i] !== 16'h5A00 + 16'(i)) begin
                miscompares++;
                $display("FAIL restore_reg[%0d]: got %h expected %h", i, rf[i], 16'h5A00 + 16'(i));
            end
        end
        vectors++;
        if (hs_n != 16) begin miscompares++; $display("FAIL restore_hs_count: got %0d expected 16", hs_n); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (hs_addr[i] !== 16'h0200 + 16'(i) || hs_we[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL restore_req[%0d]: got addr %h we %b expected %h 0", i, hs_addr[i], hs_we[i], 16'h0200 + 16'(i));
            end
        end
        vectors++;
        if (wr_n != 16 || we_len_err != 0) begin
            miscompares++;
            $display("FAIL restore_write_strobes: got %0d writes %0d long expected 16 0", wr_n, we_len_err);
        end
        vectors++;
        if (busy_cnt != 32 + lat_sum) begin
            miscompares++;
            $display("FAIL restore_busy_cycles: got %0d expected %0d", busy_cnt, 32 + lat_sum);
        end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL restore_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [15:0] ea;
        for (int i = 0; i < 16; i++) rf[i] = 16'h7700 + 16'(i);
        start_op(1'b0, 16'hFFF8);
        wait_done(200, ok);
        vectors++;
        if (!ok || hs_n != 16) begin
            miscompares++;
            $display("FAIL wrap_complete: got done=%0d hs=%0d expected 1 16", ok, hs_n);
        end
        for (int i = 0; i < 16; i++) begin
            ea = (i < 8) ? (16'hFFF8 | 16'(i)) : 16'(i - 8);
            vectors++;
            if (hs_addr[i] !== ea) begin
                miscompares++;
                $display("FAIL wrap_addr[%0d]: got %h expected %h", i, hs_addr[i], ea);
            end
        end
        vectors++;
        if (mem[16'h0000] !== 16'h7708) begin
            miscompares++;
            $display("FAIL wrap_mem0: got %h expected 7708", mem[16'h0000]);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0B00 + 16'(i);
        start_op(1'b0, 16'h0500);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                start = 1'b1; mode = 1'b1; base_addr = 16'h0900;
                ok = 1;
                break;
            end
            start = (c % 3 == 0);
            mode = ~mode;
            base_addr = base_addr + 16'h0123;
        end
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ign_done_timeout: got no done expected done"); end
        vectors++;
        if (hs_n != 16) begin miscompares++; $display("FAIL ign_hs_count: got %0d expected 16", hs_n); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (hs_addr[i] !== 16'h0500 + 16'(i) || hs_data[i] !== 16'h0B00 + 16'(i) || hs_we[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL ign_req[%0d]: got addr %h data %h we %b expected %h %h 1",
                         i, hs_addr[i], hs_data[i], hs_we[i], 16'h0500 + 16'(i), 16'h0B00 + 16'(i));
            end
        end
        vectors++;
        if (busy_cnt != 32 || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_busy_done: got busy_cycles %0d done %0d busy %b expected 32 1 0", busy_cnt, done_cnt, busy);
        end
        vectors++;
        if (we_save_err != 0) begin miscompares++; $display("FAIL ign_rf_write: got %0d expected 0", we_save_err); end
    endtask

    task automatic test_round_trip();
        bit ok;
        logic [15:0] orig [0:15];
        for (int i = 0; i < 16; i++) begin
            orig[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
            rf[i]   = orig[i];
        end
        start_op(1'b0, 16'h0400);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rt_save_timeout: got no done expected done"); end
        for (int i = 0; i < 16; i++) rf[i] = 16'hFFFF;
        lat_mode = 0;
        start_op(1'b1, 16'h0400);
        wait_done(300, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rt_restore_timeout: got no done expected done"); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (rf[i] !== orig[i]) begin
                miscompares++;
                $display("FAIL rt_reg[%0d]: got %h expected %h", i, rf[i], orig[i]);
            end
        end
        vectors++;
        if (busy_cnt != 48) begin miscompares++; $display("FAIL rt_busy_cycles: got %0d expected 48", busy_cnt); end
    endtask

    task automatic test_reset_mid_restore();
        bit found;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0600 + 16'(i)] = 16'h6600 + 16'(i);
            rf[i] = 16'h0000;
        end
        lat_mode = 2;
        start_op(1'b1, 16'h0600);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (hs_n == 6) begin
                found = 1;
                break;
            end
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL mid_reach_reg5: got %0d requests expected 6", hs_n); end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || mem_valid !== 1'b0 || wr_n != 5) begin
            miscompares++;
            $display("FAIL mid_in_wait: got busy %b valid %b writes %0d expected 1 0 5", busy, mem_valid, wr_n);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, mem_valid, mem_we, rf_write_enable} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b expected 00000", {busy, done, mem_valid, mem_we, rf_write_enable});
        end
        vectors++;
        if ({mem_addr, mem_wdata, rf_write_data} !== 48'h0 || {rf_read_reg, rf_write_reg} !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_data: got %h %h %h %h expected 0", mem_addr, mem_wdata, rf_write_data,
                     {rf_read_reg, rf_write_reg});
        end
        busy_cnt = 0; done_cnt = 0; valid_cnt = 0; wr_n = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (done_cnt != 0 || valid_cnt != 0 || wr_n != 0 || busy_cnt != 0) begin
            miscompares++;
            $display("FAIL mid_after_reset: got done %0d valid %0d writes %0d busy %0d expected all 0",
                     done_cnt, valid_cnt, wr_n, busy_cnt);
        end
        vectors++;
        if (rf[5] !== 16'h0000 || rf[4] !== 16'h6604) begin
            miscompares++;
            $display("FAIL mid_rf_state: got r4 %h r5 %h expected 6604 0000", rf[4], rf[5]);
        end
        lat_mode = 0;
        pending  = 0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        test_reset();
        test_save();
        test_save_stall();
        test_restore();
        test_wrap();
        test_start_ignored();
        test_round_trip();
        test_reset_mid_restore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
